// File: rtl/eq_cmp_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : eq_cmp_arbiter
// Description : Round-robin arbiter sharing one WIDTH-bit equality comparator
//               between two requesters (beq / bne style compare).
// Revision    : 1.0 - initial release
// ============================================================================
module eq_cmp_arbiter #(
    parameter int WIDTH     = 32,
    parameter int PRIO_INIT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             neg0,
    input  logic             neg1,
    output logic             ack0,
    output logic             ack1,
    output logic             done0,
    output logic             done1,
    output logic             result,
    output logic             busy,
    output logic [15:0]      cmp_count
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EVAL = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    // Last-grant pointer starts on the other requester so PRIO_INIT wins first.
    localparam logic c_LAST_INIT = (PRIO_INIT == 0) ? 1'b1 : 1'b0;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_neg;
    logic             r_owner;
    logic             r_last;

    logic             w_any;
    logic             w_win;
    logic             w_eq;

    always_comb begin
        w_any = req0 | req1;
        if (req0 && req1) begin
            w_win = ~r_last;
        end else begin
            w_win = req1;
        end
        w_eq = (r_a == r_b);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_neg     <= 1'b0;
            r_owner   <= 1'b0;
            r_last    <= c_LAST_INIT;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            result    <= 1'b0;
            busy      <= 1'b0;
            cmp_count <= 16'd0;
        end else begin
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            done0  <= 1'b0;
            done1  <= 1'b0;
            result <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_any) begin
                        // Only the winner's operands are captured, so an idle
                        // requester's inputs never reach the comparator.
                        r_a     <= w_win ? a1 : a0;
                        r_b     <= w_win ? b1 : b0;
                        r_neg   <= w_win ? neg1 : neg0;
                        r_owner <= w_win;
                        r_last  <= w_win;
                        ack0    <= ~w_win;
                        ack1    <= w_win;
                        busy    <= 1'b1;
                        r_state <= c_EVAL;
                    end
                end
                c_EVAL: begin
                    result  <= w_eq ^ r_neg;
                    done0   <= ~r_owner;
                    done1   <= r_owner;
                    busy    <= 1'b1;
                    r_state <= c_RESP;
                end
                c_RESP: begin
                    busy      <= 1'b0;
                    cmp_count <= cmp_count + 16'd1;
                    r_state   <= c_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eq_cmp_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_eq_cmp_arbiter
// Description : Scoreboard testbench for eq_cmp_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eq_cmp_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, req1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         neg0, neg1;
    logic         ack0, ack1, done0, done1, result, busy;
    logic [15:0]  cmp_count;

    int n_chk = 0;
    int n_err = 0;

    typedef struct packed {
        logic id;
        logic res;
    } exp_t;
    exp_t sb[$];

    eq_cmp_arbiter #(.WIDTH(W), .PRIO_INIT(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .a0        (a0),
        .b0        (b0),
        .a1        (a1),
        .b1        (b1),
        .neg0      (neg0),
        .neg1      (neg1),
        .ack0      (ack0),
        .ack1      (ack1),
        .done0     (done0),
        .done1     (done1),
        .result    (result),
        .busy      (busy),
        .cmp_count (cmp_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && (done0 || done1)) begin
            chk("done_excl", 32'(done0 & done1), 32'd0);
            if (sb.size() == 0) begin
                chk("done_unexpected", 32'(done1), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_owner", 32'(done1), 32'(e.id));
                chk("done_result", 32'(result), 32'(e.res));
            end
        end else if (!rst) begin
            chk("result_idle_zero", 32'(result), 32'd0);
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drive(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic neg);
        if (id == 1'b0) begin
            a0 = a; b0 = b; neg0 = neg; req0 = 1'b1;
        end else begin
            a1 = a; b1 = b; neg1 = neg; req1 = 1'b1;
        end
    endtask

    // One uncontended compare: drive, expect ack next cycle, done the cycle after.
    task automatic single(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic neg, input logic exp_res);
        exp_t e;
        e.id = id;
        e.res = exp_res;
        sb.push_back(e);
        drive(id, a, b, neg);
        step();
        chk("ack", 32'({ack1, ack0}), id ? 32'd2 : 32'd1);
        chk("busy_eval", 32'(busy), 32'd1);
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        chk("done", 32'({done1, done0}), id ? 32'd2 : 32'd1);
        chk("busy_resp", 32'(busy), 32'd1);
        step();
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        exp_t e;
        a0 = '0; b0 = '0; a1 = 'x; b1 = 'x; neg0 = 1'b0; neg1 = 1'b0;
        do_reset();

        chk("rst_outs", 32'({ack0, ack1, done0, done1, result, busy}), 32'd0);
        chk("rst_count", 32'(cmp_count), 32'd0);

        // Equal test with requester 1's operands left undriven
        single(1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b1);
        chk("count_1", 32'(cmp_count), 32'd1);

        // Not-equal test on MSB-only difference, then same operands as beq
        single(1'b1, 32'h0000_0001, 32'h8000_0001, 1'b1, 1'b1);
        single(1'b1, 32'h0000_0001, 32'h8000_0001, 1'b0, 1'b0);
        single(1'b0, 32'h1234_5678, 32'h1234_5679, 1'b0, 1'b0);
        chk("count_4", 32'(cmp_count), 32'd4);

        // Contention after reset: 0,1,0,1; a0 changed after first ack0
        do_reset();
        e.id = 1'b0; e.res = 1'b1; sb.push_back(e);
        e.id = 1'b1; e.res = 1'b0; sb.push_back(e);
        e.id = 1'b0; e.res = 1'b0; sb.push_back(e);
        e.id = 1'b1; e.res = 1'b0; sb.push_back(e);
        drive(1'b0, 32'd5, 32'd5, 1'b0);
        drive(1'b1, 32'd3, 32'd4, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr_ack", 32'({ack1, ack0}), (k % 2 == 1) ? 32'd2 : 32'd1);
            if (k == 0) a0 = 32'd6;
            step();
            chk("rr_done", 32'({done1, done0}), (k % 2 == 1) ? 32'd2 : 32'd1);
            if (k == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            step();
        end
        chk("rr_count", 32'(cmp_count), 32'd4);

        // Reset abort during EVAL
        do_reset();
        drive(1'b0, 32'd7, 32'd7, 1'b0);
        step();
        chk("abort_ack", 32'(ack0), 32'd1);
        rst = 1'b1;
        req0 = 1'b0;
        step();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'({done1, done0}), 32'd0);
        chk("abort_count", 32'(cmp_count), 32'd0);
        rst = 1'b0;
        step();
        chk("abort_quiet", 32'({done1, done0, busy}), 32'd0);
        single(1'b0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1, 1'b0);
        chk("abort_after_count", 32'(cmp_count), 32'd1);

        // Counter wrap from a preloaded 0xFFFF
        force dut.cmp_count = 16'hFFFF;
        step();
        release dut.cmp_count;
        step();
        chk("wrap_preload", 32'(cmp_count), 32'h0000_FFFF);
        single(1'b1, 32'd9, 32'd9, 1'b0, 1'b1);
        chk("wrap_count", 32'(cmp_count), 32'd0);

        // Late request: req1 rises during requester 0's EVAL cycle
        e.id = 1'b0; e.res = 1'b1; sb.push_back(e);
        e.id = 1'b1; e.res = 1'b1; sb.push_back(e);
        drive(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        step();
        chk("late_ack0", 32'({ack1, ack0}), 32'd1);
        req0 = 1'b0;
        drive(1'b1, 32'd1, 32'd2, 1'b1);
        step();
        chk("late_done0", 32'({done1, done0}), 32'd1);
        step();
        chk("late_idle", 32'({ack1, ack0, busy}), 32'd0);
        step();
        chk("late_ack1", 32'({ack1, ack0}), 32'd2);
        req1 = 1'b0;
        step();
        chk("late_done1", 32'({done1, done0}), 32'd2);
        step();
        chk("late_count", 32'(cmp_count), 32'd2);

        step();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
